// File: rtl/tx_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_core_pkg
//  Description : Shared helpers for the serial transmitter core: counter
//                width sizing and serial line levels.
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_core_pkg;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam logic c_LINE_IDLE  = 1'b1;
    localparam logic c_LINE_START = 1'b0;
    localparam logic c_LINE_STOP  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tx_core
//  Description : Oversampled serial transmitter. Sends start bit, WIDTH data
//                bits LSB first and a stop bit, each lasting SAMPLING_TICKS
//                baud_tick pulses. Line and busy flag are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_core #(
    parameter int WIDTH          = 8,
    parameter int SAMPLING_TICKS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data_in,
    input  logic             tx_start,
    input  logic             baud_tick,
    output logic             tx,
    output logic             tx_busy
);
    import tx_core_pkg::*;

    localparam int c_TICK_W = cnt_width(SAMPLING_TICKS);
    localparam int c_BIT_W  = cnt_width(WIDTH);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SAMPLING_TICKS - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = c_ST_IDLE,
        START = c_ST_START,
        DATA  = c_ST_DATA,
        STOP  = c_ST_STOP
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [WIDTH-1:0]    shift_reg,  w_shift_nxt;
    logic [c_TICK_W-1:0] r_tick_cnt, w_tick_nxt;
    logic [c_BIT_W-1:0]  r_bit_cnt,  w_bit_nxt;
    logic                r_tx,       w_tx_nxt;
    logic                r_busy,     w_busy_nxt;

    logic [WIDTH-1:0]    w_shifted;
    logic                w_tick_last;

    assign w_shifted   = shift_reg >> 1;
    assign w_tick_last = (r_tick_cnt == c_TICK_LAST);

    assign tx      = r_tx;
    assign tx_busy = r_busy;

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            shift_reg  <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= c_LINE_IDLE;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            shift_reg  <= w_shift_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state logic; the line value is computed one edge early so tx
    // changes on the same edge as the state it belongs to.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = shift_reg;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;

        case (r_state)
            IDLE: begin
                w_tx_nxt   = c_LINE_IDLE;
                w_busy_nxt = 1'b0;
                if (tx_start) begin
                    w_shift_nxt = tx_data_in;
                    w_tick_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = START;
                    w_tx_nxt    = c_LINE_START;
                    w_busy_nxt  = 1'b1;
                end
            end

            START: begin
                if (baud_tick) begin
                    if (w_tick_last) begin
                        w_tick_nxt  = '0;
                        w_state_nxt = DATA;
                        w_tx_nxt    = shift_reg[0];
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (baud_tick) begin
                    if (w_tick_last) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = w_shifted;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            // Bit counter parks at its terminal value.
                            w_state_nxt = STOP;
                            w_tx_nxt    = c_LINE_STOP;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                            w_tx_nxt  = w_shifted[0];
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (baud_tick) begin
                    if (w_tick_last) begin
                        w_tick_nxt  = '0;
                        w_state_nxt = IDLE;
                        w_tx_nxt    = c_LINE_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = c_LINE_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_core
//  Description : Self-checking bench for tx_core: hand-derived frame table,
//                scripted corner cases and random traffic against a
//                frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_core;

    localparam int W     = 8;
    localparam int S     = 16;
    localparam int FRAME = (W + 2) * S;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] tx_data_in;
    logic         tx_start;
    logic         baud_tick;
    logic         tx;
    logic         tx_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is a 10-slot word {stop, data, start}; the
    // line shows slot (ticks_since_accept / S) until FRAME ticks have passed.
    logic           m_busy;
    int             m_n;
    logic [W+1:0]   m_frame;
    logic           tk;

    typedef struct {
        logic [W-1:0] data;
        logic [W+1:0] slots;   // slot i = line level during i-th bit time
    } vec_t;

    vec_t vecs [4];

    tx_core #(.WIDTH(W), .SAMPLING_TICKS(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data_in (tx_data_in),
        .tx_start   (tx_start),
        .baud_tick  (baud_tick),
        .tx         (tx),
        .tx_busy    (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        return m_busy ? m_frame[m_n / S] : 1'b1;
    endfunction

    // One clock: drive inputs at negedge, update the model at the edge,
    // compare outputs 1 ns later.
    task automatic step(input logic s, input logic [W-1:0] d, input logic t);
        @(negedge clk);
        tx_start   = s;
        tx_data_in = d;
        baud_tick  = t;
        @(posedge clk);
        if (!m_busy) begin
            if (s) begin
                m_busy  = 1'b1;
                m_n     = 0;
                m_frame = {1'b1, d, 1'b0};
            end
        end else if (t) begin
            m_n++;
            if (m_n == FRAME) m_busy = 1'b0;
        end
        #1;
        chk("model_tx", {31'd0, tx}, {31'd0, model_tx()});
        chk("model_busy", {31'd0, tx_busy}, {31'd0, m_busy});
    endtask

    // Alternating baud ticks, as in the directed scenarios.
    task automatic step_alt(input logic s, input logic [W-1:0] d);
        tk = ~tk;
        step(s, d, tk);
    endtask

    task automatic run_until_idle(input int bound);
        int c;
        c = 0;
        while (m_busy && c < bound) begin
            step_alt(1'b0, W'($urandom));
            c++;
        end
        if (m_busy) chk("frame_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        int gap;
        int accepts;
        logic prev_busy;

        vecs[0] = '{data: 8'hA5, slots: 10'h34A};
        vecs[1] = '{data: 8'h3C, slots: 10'h278};
        vecs[2] = '{data: 8'hFF, slots: 10'h3FE};
        vecs[3] = '{data: 8'h00, slots: 10'h200};

        m_busy = 1'b0; m_n = 0; m_frame = '0; tk = 1'b0;
        tx_start = 1'b0; tx_data_in = '0; baud_tick = 1'b0;

        // Reset held 20 ns, then 20 ns of idle.
        rst_n = 1'b0;
        #20;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_shift", {24'd0, dut.shift_reg}, 32'd0);
        rst_n = 1'b1;
        step_alt(1'b0, 8'h00);
        step_alt(1'b0, 8'h00);

        // Table frames back to back, sampled mid-slot.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vecs[i].data, 1'b0);
            chk("accept_busy", {31'd0, tx_busy}, 32'd1);
            n = 0;
            for (int c = 0; c < 400 && n < FRAME; c++) begin
                tk = ~tk;
                step(1'b0, W'($urandom), tk);
                if (tk) begin
                    n++;
                    if (n % S == S / 2)
                        chk("tbl_bit", {31'd0, tx}, {31'd0, vecs[i].slots[n / S]});
                    if (n == FRAME - 1)
                        chk("tbl_busy_hold", {31'd0, tx_busy}, 32'd1);
                    if (n == FRAME)
                        chk("tbl_busy_fall", {31'd0, tx_busy}, 32'd0);
                end
            end
            if (n != FRAME) chk("tbl_timeout", 32'd1, 32'd0);
        end

        // Start pulse mid-frame with other data is ignored.
        step(1'b1, 8'hC3, 1'b0);
        while (m_busy && m_n < 40) step_alt(1'b0, 8'h00);
        step_alt(1'b1, 8'h0F);
        run_until_idle(400);
        for (int c = 0; c < 20; c++) step_alt(1'b0, 8'h0F);
        chk("no_extra_frame", {31'd0, tx_busy}, 32'd0);

        // Start held high continuously: exactly one idle edge between frames.
        gap = 0; accepts = 0; prev_busy = 1'b0;
        for (int c = 0; c < 800 && accepts < 2; c++) begin
            step_alt(1'b1, 8'h96);
            if (!tx_busy) gap++;
            if (tx_busy && !prev_busy) begin
                if (accepts == 1) chk("restart_gap", gap, 32'd1);
                accepts++;
                gap = 0;
            end
            prev_busy = tx_busy;
        end
        if (accepts < 2) chk("restart_timeout", 32'd1, 32'd0);
        run_until_idle(400);
        step_alt(1'b0, 8'h00);

        // Baud ticks stop for 50 cycles in the middle of the data bits.
        step(1'b1, 8'h6D, 1'b0);
        while (m_busy && m_n < 60) step_alt(1'b0, 8'h00);
        for (int c = 0; c < 50; c++) step(1'b0, 8'hFF, 1'b0);
        run_until_idle(400);

        // Asynchronous reset during the data bits.
        step(1'b1, 8'hE7, 1'b0);
        while (m_busy && m_n < 70) step_alt(1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", {31'd0, tx}, 32'd1);
        chk("async_rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("async_rst_shift", {24'd0, dut.shift_reg}, 32'd0);
        m_busy = 1'b0; m_n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step_alt(1'b0, 8'h00);
        step(1'b1, 8'h5A, 1'b0);
        run_until_idle(400);

        // Random traffic, random tick pattern.
        for (int c = 0; c < 6000; c++)
            step(($urandom % 40) == 0, W'($urandom), 1'($urandom % 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
